// File: rtl/regalu_pkg.sv
// ============================================================================
// Module      : regalu_pkg
// Description : Shared types and constants for the reg_alu_exec execute unit:
//               ALU opcode enumeration, sequencer state enumeration and the
//               opcode width.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package regalu_pkg;

    localparam int OP_W = 3;

    // Opcode 111 is PASS A by default, MUL when the multiplier is built in
    typedef enum logic [OP_W-1:0] {
        OP_ADD      = 3'b000,
        OP_SUB      = 3'b001,
        OP_AND      = 3'b010,
        OP_OR       = 3'b011,
        OP_XOR      = 3'b100,
        OP_NOTA     = 3'b101,
        OP_SHL1     = 3'b110,
        OP_PASS_MUL = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_READ = 2'b01,
        ST_EXEC = 2'b10,
        ST_WB   = 2'b11
    } state_e;

endpackage : regalu_pkg

`default_nettype wire

// File: rtl/reg_file.sv
// ============================================================================
// Module      : reg_file
// Description : NUM_REGS x DATA_W register file with two combinational read
//               ports and one synchronous write port. Entry 0 is cleared on
//               reset and never written, so it always reads as zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] r_mem [NUM_REGS];

    // Storage: async clear of every entry, writes to address 0 are dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Entry 0 holds zero permanently, so a plain indexed read suffices
    assign rdata_a = r_mem[raddr_a];
    assign rdata_b = r_mem[raddr_b];

endmodule : reg_file

`default_nettype wire

// File: rtl/reg_alu_exec.sv
// ============================================================================
// Module      : reg_alu_exec
// Description : Multi-cycle execute unit: register file, 8-operation ALU and
//               an IDLE/READ/EXEC/WB sequencer with a start/done handshake.
//               Host loads are accepted only in IDLE and share the single
//               register-file write port with writeback.
//               Optional macro REGALU_MUL_EN turns opcode 111 from PASS A into
//               a single-cycle multiply (low half result, carry = high half
//               nonzero).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_alu_exec
    import regalu_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [OP_W-1:0]   op,
    input  logic [ADDR_W-1:0] ra_addr,
    input  logic [ADDR_W-1:0] rb_addr,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              carry
);

    state_e            r_state;
    alu_op_e           r_op;
    logic [ADDR_W-1:0] r_ra;
    logic [ADDR_W-1:0] r_rb;
    logic [ADDR_W-1:0] r_wr;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_result;
    logic              r_zero;
    logic              r_carry;
    logic              r_done;
    logic              r_busy;

    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_rdata_a;
    logic [DATA_W-1:0] w_rdata_b;
    logic [DATA_W-1:0] w_alu_res;
    logic              w_alu_carry;
    logic [DATA_W:0]   w_sum;
    logic [DATA_W:0]   w_diff;

    // Write port: loads only in IDLE, writeback only in WB, so they never meet
    always_comb begin
        w_we    = 1'b0;
        w_waddr = ld_addr;
        w_wdata = ld_data;
        if (r_state == ST_WB) begin
            w_we    = 1'b1;
            w_waddr = r_wr;
            w_wdata = r_result;
        end else if (r_state == ST_IDLE) begin
            w_we    = ld_en;
        end
    end

    reg_file #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (w_we),
        .waddr   (w_waddr),
        .wdata   (w_wdata),
        .raddr_a (r_ra),
        .rdata_a (w_rdata_a),
        .raddr_b (r_rb),
        .rdata_b (w_rdata_b)
    );

    assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff = {1'b0, r_a} - {1'b0, r_b};

`ifdef REGALU_MUL_EN
    logic [2*DATA_W-1:0] w_prod;
    assign w_prod = r_a * r_b;
`endif

    // ALU: pure function of the latched operands and opcode
    always_comb begin
        w_alu_res   = '0;
        w_alu_carry = 1'b0;
        case (r_op)
            OP_ADD: begin
                w_alu_res   = w_sum[DATA_W-1:0];
                w_alu_carry = w_sum[DATA_W];
            end
            OP_SUB: begin
                // Top bit of the widened difference is the borrow (A < B)
                w_alu_res   = w_diff[DATA_W-1:0];
                w_alu_carry = w_diff[DATA_W];
            end
            OP_AND:  w_alu_res = r_a & r_b;
            OP_OR:   w_alu_res = r_a | r_b;
            OP_XOR:  w_alu_res = r_a ^ r_b;
            OP_NOTA: w_alu_res = ~r_a;
            OP_SHL1: begin
                w_alu_res   = {r_a[DATA_W-2:0], 1'b0};
                w_alu_carry = r_a[DATA_W-1];
            end
            OP_PASS_MUL: begin
`ifdef REGALU_MUL_EN
                w_alu_res   = w_prod[DATA_W-1:0];
                w_alu_carry = |w_prod[2*DATA_W-1:DATA_W];
`else
                w_alu_res   = r_a;
`endif
            end
            default: begin
                w_alu_res   = '0;
                w_alu_carry = 1'b0;
            end
        endcase
    end

    // Sequencer: latch fields on start, operands in READ, result in EXEC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_op     <= OP_ADD;
            r_ra     <= '0;
            r_rb     <= '0;
            r_wr     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_carry  <= 1'b0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_op    <= alu_op_e'(op);
                        r_ra    <= ra_addr;
                        r_rb    <= rb_addr;
                        r_wr    <= wr_addr;
                        r_busy  <= 1'b1;
                        r_state <= ST_READ;
                    end
                end
                ST_READ: begin
                    r_a     <= w_rdata_a;
                    r_b     <= w_rdata_b;
                    r_state <= ST_EXEC;
                end
                ST_EXEC: begin
                    r_result <= w_alu_res;
                    r_zero   <= (w_alu_res == '0);
                    r_carry  <= w_alu_carry;
                    r_done   <= 1'b1;
                    r_state  <= ST_WB;
                end
                ST_WB: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;
    assign zero   = r_zero;
    assign carry  = r_carry;

endmodule : reg_alu_exec

`default_nettype wire
